apb_mem_responder: RTL and testbench
====================================

# apb_mem_responder

APB3 completer (responder) backed by a small word-addressed register memory, with a fixed, parameterised number of wait states and error signalling on illegal addresses. It is the DUT-side counterpart of the APB initiator BFM used in our unit-test examples: the BFM drives requests and this block answers them. Testcases exercise the BFM against it to check handshake, wait-state and error handling end to end.

## Interface
- ADDR_WIDTH, 8, width of paddr in bits
- DATA_WIDTH, 32, width of pwdata/prdata in bits
- DEPTH, 16, number of DATA_WIDTH words; legal word index 0..DEPTH-1
- WAIT_CYCLES, 0, pready-low cycles inserted in every access phase (0..15)

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- paddr  input  ADDR_WIDTH  byte address; word index = paddr[ADDR_WIDTH-1:2]
- psel  input  1  select
- penable  input  1  access-phase qualifier
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  DATA_WIDTH  write data
- prdata  output  DATA_WIDTH  read data, valid only while pready=1
- pready  output  1  transfer completes on the edge where psel&penable&pready
- pslverr  output  1  error response, valid only while pready=1

## Operation
- All outputs registered. Reset: prdata=0, pready=0, pslverr=0, state IDLE, wait counter 0, all memory words 0.
- States: IDLE, SETUP, WAIT, ACCESS.
  - IDLE: psel&!penable -> SETUP. penable without a setup cycle is ignored (stay IDLE).
  - SETUP (one cycle): latch paddr, pwrite, pwdata; decode error; load counter with WAIT_CYCLES. -> ACCESS if WAIT_CYCLES=0, else WAIT.
  - WAIT: pready=0; counter decrements each cycle; when it reaches 1 -> ACCESS.
  - ACCESS: pready=1 for exactly one cycle; on that edge the transfer completes. Next: psel&!penable -> SETUP (back-to-back), otherwise IDLE.
- Error decode: paddr[1:0]!=0 or word index >= DEPTH -> pslverr=1 in ACCESS; writes suppressed, prdata=0.
- Write: memory word updated on the completing edge (ACCESS, psel&penable&pwrite, no error), using latched pwdata.
- Read: prdata loaded with mem[index] on the edge entering ACCESS; prdata returns to 0 on the edge leaving ACCESS.
- psel deasserted in WAIT or ACCESS: abort -> IDLE next edge, pready/pslverr/prdata forced 0, no write.
- Changes of paddr/pwrite/pwdata after SETUP are ignored (latched values used).

## Timing
- Setup cycle T0 (psel=1, penable=0). Access starts T1. pready=1 in cycle T1+WAIT_CYCLES; transfer ends at end of that cycle.
- Total transfer length = 2 + WAIT_CYCLES cycles; back-to-back throughput is one transfer per 2 + WAIT_CYCLES cycles.
- Read-after-write to same address in the next transfer returns the new data.
- rst_n low at any point, including mid-transfer: outputs 0 immediately (asynchronously), memory cleared, state IDLE; in-flight write is not performed.
- pready and pslverr are never high outside ACCESS; pslverr never high while pready=0.

## Test plan
- Reset: rst_n=0 mid-WAIT with WAIT_CYCLES=3 -> pready/pslverr/prdata=0 same cycle; afterwards read of addr 0x04 returns 0.
- Write/read, WAIT_CYCLES=0: write 0xDEADBEEF to 0x08, then read 0x08 -> pready high in second cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- Wait states, WAIT_CYCLES=3: read 0x00 -> pready low for 3 access cycles, high on 4th; transfer spans 5 cycles.
- Errors: write 0x12345678 to 0x40 (index 16) and to 0x05 (misaligned) -> pslverr=1 with pready, prdata=0; subsequent reads of 0x00 and 0x04 return 0.
- Back-to-back: 4 writes to 0x00..0x0C with no idle cycles, then 4 reads -> each completes in 2+WAIT_CYCLES cycles, data matches.
- Abort: drop psel during WAIT of a write to 0x0C with 0xA5A5A5A5 -> pready never asserted; later read of 0x0C returns previous value.

Source files
------------

// File: rtl/apb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : apb_mem_responder
// Brief    : APB3 completer backed by a word-addressed register memory, with
//            a fixed number of wait states and error response on illegal
//            (misaligned or out-of-range) addresses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The setup cycle is the cycle in which IDLE (or ACCESS, for a request
    // arriving straight after completion) sees psel & !penable. Its work
    // (latch, decode, counter load) happens on the edge that closes it, so
    // with registered outputs pready can rise in the very next cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [MEM_AW-1:0]       idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

    logic [IDX_W-1:0]        in_idx;
    logic [MEM_AW-1:0]       in_midx;
    logic                    in_err;
    logic                    start;

    // Decode the live bus address; only meaningful during a setup cycle.
    always_comb begin
        in_idx  = paddr[ADDR_WIDTH-1:2];
        in_midx = in_idx[MEM_AW-1:0];
        in_err  = (paddr[1:0] != 2'b00) || (32'(in_idx) >= 32'(DEPTH));
        start   = psel && !penable && (state_q == IDLE || state_q == ACCESS);
    end

    // Next-state, memory update and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_d     = mem_q;

        case (state_q)
            IDLE: begin
                // penable without a preceding setup cycle is ignored
                state_d = IDLE;
            end
            WAIT: begin
                if (!psel) begin
                    // aborted by the initiator: no write, outputs stay low
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = ACCESS;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (!err_q && !write_q) ? mem_q[idx_q] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                // completing edge: commit a legal write with latched data
                if (psel && penable && write_q && !err_q) begin
                    mem_d[idx_q] = wdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            idx_d   = in_midx;
            err_d   = in_err;
            write_d = pwrite;
            wdata_d = pwdata;
            cnt_d   = 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
                state_d   = ACCESS;
                pready_d  = 1'b1;
                pslverr_d = in_err;
                prdata_d  = (!in_err && !pwrite) ? mem_d[in_midx] : '0;
            end else begin
                state_d = WAIT;
            end
        end
    end

    // State, latched request, outputs and memory; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            mem_q     <= mem_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mem_responder
// Brief    : Self-checking bench driving two responders (0 and 3 wait states)
//            through handshake, error, back-to-back, abort and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  paddr;
    logic        penable, pwrite;
    logic [31:0] pwdata;
    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    always #5 clk = ~clk;

    apb_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem0 [16];
    logic [31:0] mem3 [16];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? pslverr0 : pslverr3;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata3;
    endfunction

    task automatic set_psel(input int d, input logic v);
        if (d == 0) psel0 = v;
        else        psel3 = v;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            mem3[i] = '0;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // One APB transfer; expectation pushed before driving, popped on pready.
    task automatic xfer(input string tag, input int d, input logic wr,
                        input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        logic err;
        int   idx;
        int   cyc;
        logic seen;
        logic bad;
        err        = (a[1:0] != 2'b00) || (a[7:2] >= 6'd16);
        idx        = int'(a[5:2]);
        e.err      = err;
        e.cycles   = 2 + ((d == 0) ? 0 : 3);
        e.chk_data = !wr || err;
        e.data     = (!wr && !err) ? ((d == 0) ? mem0[idx] : mem3[idx]) : 32'h0;
        if (wr && !err) begin
            if (d == 0) mem0[idx] = wd;
            else        mem3[idx] = wd;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        set_psel(d, 1'b1); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        cyc = 1;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 2;
        // request fields change after setup; the responder must ignore them
        paddr = 8'hFD; pwdata = ~wd; pwrite = ~wr;
        seen = 1'b0;
        bad  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (serr(d) && !rdy(d)) bad = 1'b1;
            if (rdy(d)) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        e = sb.pop_front();
        check({tag, " pready"}, 64'(seen), 64'd1);
        check({tag, " slverr_without_ready"}, 64'(bad), 64'd0);
        if (seen) begin
            check({tag, " cycles"}, 64'(cyc), 64'(e.cycles));
            check({tag, " pslverr"}, 64'(serr(d)), 64'(e.err));
            if (e.chk_data) check({tag, " prdata"}, 64'(rdat(d)), 64'(e.data));
        end
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        clear_models();
        repeat (3) @(negedge clk);
        check("reset pready0", 64'(pready0), 64'd0);
        check("reset pslverr0", 64'(pslverr0), 64'd0);
        check("reset prdata0", 64'(prdata0), 64'd0);
        check("reset pready3", 64'(pready3), 64'd0);
        check("reset pslverr3", 64'(pslverr3), 64'd0);
        check("reset prdata3", 64'(prdata3), 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // zero wait states: write then read back
        xfer("w0 wr08", 0, 1'b1, 8'h08, 32'hDEADBEEF);
        idle();
        xfer("w0 rd08", 0, 1'b0, 8'h08, 32'h0);
        idle();

        // illegal addresses
        xfer("w0 wr40", 0, 1'b1, 8'h40, 32'h12345678);
        xfer("w0 wr05", 0, 1'b1, 8'h05, 32'h12345678);
        xfer("w0 rd00", 0, 1'b0, 8'h00, 32'h0);
        xfer("w0 rd04", 0, 1'b0, 8'h04, 32'h0);
        idle();

        // back-to-back, zero wait states
        for (int i = 0; i < 4; i++)
            xfer("w0 b2b wr", 0, 1'b1, 8'(i * 4), 32'h1000_0001 * (i + 1));
        for (int i = 0; i < 4; i++)
            xfer("w0 b2b rd", 0, 1'b0, 8'(i * 4), 32'h0);
        idle();

        // three wait states
        xfer("w3 rd00", 3, 1'b0, 8'h00, 32'h0);
        xfer("w3 rd41", 3, 1'b0, 8'h41, 32'h0);
        for (int i = 0; i < 4; i++)
            xfer("w3 b2b wr", 3, 1'b1, 8'(i * 4), 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 4; i++)
            xfer("w3 b2b rd", 3, 1'b0, 8'(i * 4), 32'h0);
        idle();

        // abort during WAIT: write to 0x0C must not land
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        if (pready3) seen = 1'b1;
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (pready3) seen = 1'b1;
        end
        check("abort pready", 64'(seen), 64'd0);
        xfer("w3 rd0C after abort", 3, 1'b0, 8'h0C, 32'h0);
        idle();

        // reset mid-WAIT
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst wait pready3", 64'(pready3), 64'd0);
        check("rst wait pslverr3", 64'(pslverr3), 64'd0);
        check("rst wait prdata3", 64'(prdata3), 64'd0);
        psel3 = 1'b0; penable = 1'b0;
        clear_models();
        @(posedge clk); #1; rst_n = 1'b1;
        xfer("w3 rd04 after reset", 3, 1'b0, 8'h04, 32'h0);
        idle();

        // reset while pready is high on an in-flight write
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h11111111;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("pre-rst access pready0", 64'(pready0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst access pready0", 64'(pready0), 64'd0);
        check("rst access pslverr0", 64'(pslverr0), 64'd0);
        psel0 = 1'b0; penable = 1'b0;
        clear_models();
        @(posedge clk); #1; rst_n = 1'b1;
        xfer("w0 rd10 after reset", 0, 1'b0, 8'h10, 32'h0);
        xfer("w0 rd08 after reset", 0, 1'b0, 8'h08, 32'h0);
        idle();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
